// File: rtl/div_ctrl.sv
// Sign-handling sequencer around an external combinational unsigned divider array.
// Normal result SETTLE cycles after accept; divide-by-zero / signed overflow bypass the array (1 cycle); one op in flight, result held until out_ready.
module div_ctrl #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  output logic             div_sgn,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz,
  output logic             ovf
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_sa;
  logic             r_sb;
  logic [WIDTH-1:0] r_div_dividend;
  logic [WIDTH-1:0] r_div_divisor;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;
  logic             r_ovf;
  logic             r_out_valid;

  logic             w_sa;
  logic             w_sb;
  logic             w_div_zero;
  logic             w_sovf;
  logic [WIDTH-1:0] w_min_neg;

  assign w_min_neg  = {1'b1, {(WIDTH-1){1'b0}}};
  assign w_sa       = signed_op & dividend[WIDTH-1];
  assign w_sb       = signed_op & divisor[WIDTH-1];
  assign w_div_zero = (divisor == '0);
  // Only -MIN / -1 overflows; its true quotient is not representable.
  assign w_sovf     = signed_op && (dividend == w_min_neg) && (divisor == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_sa           <= 1'b0;
      r_sb           <= 1'b0;
      r_div_dividend <= '0;
      r_div_divisor  <= '0;
      r_quotient     <= '0;
      r_remainder    <= '0;
      r_dbz          <= 1'b0;
      r_ovf          <= 1'b0;
      r_out_valid    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sa           <= w_sa;
            r_sb           <= w_sb;
            r_div_dividend <= w_sa ? -dividend : dividend;
            r_div_divisor  <= w_sb ? -divisor  : divisor;
            if (w_div_zero) begin
              r_quotient  <= '1;
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
              r_ovf       <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else if (w_sovf) begin
              r_quotient  <= w_min_neg;
              r_remainder <= '0;
              r_dbz       <= 1'b0;
              r_ovf       <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_cnt   <= CW'(SETTLE - 1);
              r_dbz   <= 1'b0;
              r_ovf   <= 1'b0;
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            // Remainder follows the dividend's sign (truncating division).
            r_quotient  <= (r_sa ^ r_sb) ? -div_q : div_q;
            r_remainder <= r_sa ? -div_r : div_r;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready     = (r_state == IDLE);
  assign out_valid    = r_out_valid;
  assign quotient     = r_quotient;
  assign remainder    = r_remainder;
  assign dbz          = r_dbz;
  assign ovf          = r_ovf;
  assign div_dividend = r_div_dividend;
  assign div_divisor  = r_div_divisor;
  assign div_sgn      = 1'b0;

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized and directed bench for div_ctrl with a behavioural integer-division reference.
module tb_div_ctrl;

  localparam int W      = 16;
  localparam int SETTLE = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         signed_op = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] div_dividend;
  logic [W-1:0] div_divisor;
  logic         div_sgn;
  logic [W-1:0] div_q;
  logic [W-1:0] div_r;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dbz;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  // Expected result of the operation currently in flight.
  bit           pending = 1'b0;
  logic [W-1:0] exp_q, exp_r, exp_ma, exp_mb;
  logic         exp_dbz, exp_ovf;
  int           exp_lat;

  always #5 clk = ~clk;

  div_ctrl #(.WIDTH(W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .signed_op(signed_op), .dividend(dividend), .divisor(divisor),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_sgn(div_sgn),
    .div_q(div_q), .div_r(div_r), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .dbz(dbz), .ovf(ovf)
  );

  // Unsigned divider array stand-in.
  assign div_q = (div_divisor == '0) ? '1 : div_dividend / div_divisor;
  assign div_r = (div_divisor == '0) ? div_dividend : div_dividend % div_divisor;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint to_int(input logic s, input logic [W-1:0] v);
    longint x;
    x = longint'(v);
    if (s && v[W-1]) x = x - (longint'(1) << W);
    return x;
  endfunction

  // Reference: truncating integer division on the interpreted operand values.
  task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic d, output logic o,
                       output logic [W-1:0] ma, output logic [W-1:0] mb, output int lat);
    longint av, bv, qv, rv, t;
    av = to_int(s, a);
    bv = to_int(s, b);
    t  = (av < 0) ? -av : av;  ma = t[W-1:0];
    t  = (bv < 0) ? -bv : bv;  mb = t[W-1:0];
    d = 1'b0; o = 1'b0;
    if (bv == 0) begin
      q = '1; r = a; d = 1'b1; lat = 0;
    end else if (s && av == -(longint'(1) << (W-1)) && bv == -1) begin
      q = {1'b1, {(W-1){1'b0}}}; r = '0; o = 1'b1; lat = 0;
    end else begin
      qv = av / bv;
      rv = av % bv;
      q = qv[W-1:0];
      r = rv[W-1:0];
      lat = SETTLE;
    end
  endtask

  // Per-cycle comparison against the reference.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("div_sgn", 32'(div_sgn), 32'd0);
      if (pending && out_valid) begin
        chk("quotient", 32'(quotient), 32'(exp_q));
        chk("remainder", 32'(remainder), 32'(exp_r));
        chk("dbz", 32'(dbz), 32'(exp_dbz));
        chk("ovf", 32'(ovf), 32'(exp_ovf));
      end else if (pending && !in_ready) begin
        chk("wait_div_dividend", 32'(div_dividend), 32'(exp_ma));
        chk("wait_div_divisor", 32'(div_divisor), 32'(exp_mb));
      end
    end
  end

  // One request: latency = edges after the accept edge until out_valid is seen.
  task automatic do_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, input bit lit,
                       input logic [W-1:0] lq, input logic [W-1:0] lr,
                       input logic ld, input logic lo);
    int n;
    int lat;
    logic [W-1:0] sq, sr;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    model(s, a, b, exp_q, exp_r, exp_dbz, exp_ovf, exp_ma, exp_mb, exp_lat);
    signed_op = s; dividend = a; divisor = b; in_valid = 1'b1;
    pending = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    signed_op = $urandom_range(0, 1); dividend = W'($urandom); divisor = W'($urandom);
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("latency", 32'(lat), 32'(exp_lat));
    if (lit) begin
      chk("lit_quotient", 32'(quotient), 32'(lq));
      chk("lit_remainder", 32'(remainder), 32'(lr));
      chk("lit_dbz", 32'(dbz), 32'(ld));
      chk("lit_ovf", 32'(ovf), 32'(lo));
    end
    sq = quotient; sr = remainder;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_q_stable", 32'(quotient), 32'(sq));
      chk("hold_r_stable", 32'(remainder), 32'(sr));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    in_valid = 1'b0;
    pending = 1'b0;
    @(negedge clk);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic s;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_div_dividend", 32'(div_dividend), 32'd0);
    chk("rst_div_divisor", 32'(div_divisor), 32'd0);
    chk("rst_flags", 32'({dbz, ovf}), 32'd0);
    #20 rst_n = 1'b1;

    do_op(1'b0, 16'd100,  16'd7,    0, 1'b1, 16'd14,   16'd2,    1'b0, 1'b0);
    do_op(1'b1, 16'hFFF9, 16'h0002, 0, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
    do_op(1'b1, 16'h0007, 16'hFFFE, 1, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 1'b0);
    do_op(1'b0, 16'h8000, 16'hFFFF, 0, 1'b1, 16'h0000, 16'h8000, 1'b0, 1'b0);
    do_op(1'b0, 16'h1234, 16'h0000, 0, 1'b1, 16'hFFFF, 16'h1234, 1'b1, 1'b0);
    do_op(1'b1, 16'h1234, 16'h0000, 0, 1'b1, 16'hFFFF, 16'h1234, 1'b1, 1'b0);
    do_op(1'b1, 16'h8000, 16'hFFFF, 0, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1);
    do_op(1'b1, 16'h8000, 16'h0002, 0, 1'b1, 16'hC000, 16'h0000, 1'b0, 1'b0);
    // Backpressure: 5 cycles of out_ready=0 with in_valid asserted throughout.
    do_op(1'b0, 16'd1000, 16'd33,   5, 1'b1, 16'd30,   16'd10,   1'b0, 1'b0);

    // Reset one cycle into WAIT discards the operation.
    @(negedge clk);
    signed_op = 1'b0; dividend = 16'd100; divisor = 16'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_quotient", 32'(quotient), 32'd0);
    chk("mid_rst_remainder", 32'(remainder), 32'd0);
    chk("mid_rst_div_dividend", 32'(div_dividend), 32'd0);
    chk("mid_rst_div_divisor", 32'(div_divisor), 32'd0);
    chk("mid_rst_flags", 32'({dbz, ovf}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 16'd9, 16'd3, 0, 1'b1, 16'd3, 16'd0, 1'b0, 1'b0);

    for (int k = 0; k < 200; k++) begin
      s = 1'(($urandom_range(0, 1)));
      a = W'($urandom);
      b = W'($urandom);
      case ($urandom_range(0, 9))
        0: b = '0;
        1: begin a = 16'h8000; b = 16'hFFFF; end
        2: b = W'($urandom_range(1, 5));
        3: b = -W'($urandom_range(1, 5));
        default: ;
      endcase
      do_op(s, a, b, $urandom_range(0, 3), 1'b0, '0, '0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing and sign-handling front/back end for the 16-bit CISC datapath's combinational non-restoring divider. It accepts a divide request over a valid/ready handshake, converts signed operands to magnitudes, and drives the divider array with sign mode forced to unsigned. It holds those operands stable for a fixed settle window, then captures the raw quotient/remainder and applies sign correction. It also short-circuits divide-by-zero and signed overflow without using the array.

## Interface
- WIDTH, 16, operand/result width (≥2)
- SETTLE, 3, cycles the divider operands are held before results are sampled (≥1); the divider array path is a SETTLE-cycle multicycle path

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request; equals (state==IDLE)
- signed_op  in  1  1 = two's-complement divide, 0 = unsigned
- dividend  in  WIDTH  numerator
- divisor  in  WIDTH  denominator
- div_dividend  out  WIDTH  registered magnitude driven to the divider Dividend
- div_divisor  out  WIDTH  registered magnitude driven to the divider Divisor
- div_sgn  out  1  divider sign-mode input; constant 0
- div_q  in  WIDTH  divider quotient (unsigned)
- div_r  in  WIDTH  divider remainder (unsigned)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quotient  out  WIDTH  final quotient
- remainder  out  WIDTH  final remainder
- dbz  out  1  divide-by-zero flag, qualified by out_valid
- ovf  out  1  signed-overflow flag, qualified by out_valid

## Operation
- States: IDLE, WAIT, DONE. Reset: state IDLE and cnt=0. quotient, remainder, div_dividend, div_divisor, dbz, ovf, out_valid are all 0.
- IDLE, in_valid=1 (accept edge): latch sa = signed_op & dividend[MSB] and sb = signed_op & divisor[MSB].
  - div_dividend = sa ? −dividend : dividend (mod 2^WIDTH).
  - div_divisor = sb ? −divisor : divisor. The magnitude of the most-negative value is its own bit pattern, which is correct as unsigned.
- Accept-edge priority:
  1. divisor==0: go to DONE with quotient = all-ones, remainder = dividend (raw input), dbz=1, ovf=0.
  2. Otherwise, if signed_op=1, dividend = 1000…0 and divisor = all-ones: go to DONE with quotient = 1000…0, remainder = 0, ovf=1, dbz=0.
  3. Otherwise: go to WAIT with cnt = SETTLE−1, and clear dbz and ovf.
- WAIT: if cnt==0, capture:
  - quotient = (sa^sb) ? −div_q : div_q
  - remainder = sa ? −div_r : div_r (remainder takes the dividend's sign)
  - go to DONE.
  - Otherwise cnt decrements.
- DONE: out_valid=1. quotient, remainder, dbz and ovf are held stable. On out_ready=1, go to IDLE and drop out_valid.
- div_dividend and div_divisor change only on an accept edge. They are stable for the whole of WAIT.
- in_valid is ignored outside IDLE. There is no queuing and no back-to-back overlap.

## Timing
- Normal path: accept at edge E0. Capture at edge E(SETTLE). out_valid is high from the cycle after E(SETTLE), so latency is SETTLE cycles.
- dbz and ovf path: out_valid is high the cycle after the accept edge, so latency is 1 cycle.
- Minimum initiation interval is SETTLE+2 cycles: accept, SETTLE−1 further WAIT cycles, DONE, then IDLE. The dbz/ovf path takes 2 cycles.
- out_valid/out_ready follow standard valid/ready rules: the transfer happens on a rising edge with both high. The same-cycle DONE→IDLE transition does not also accept a new request; the earliest new accept is the next edge.
- Asynchronous reset at any time, including mid-WAIT or during DONE, returns immediately to reset values. The in-flight operation is discarded and no result is produced.

## Test plan
- Unsigned 100 ÷ 7 (WIDTH=16, SETTLE=3): quotient=14, remainder=2, flags 0. out_valid rises exactly 3 cycles after the accept edge, and div_divisor=7 throughout WAIT.
- Signed cases:
  - 0xFFF9 ÷ 0x0002 (−7/2) → quotient 0xFFFD, remainder 0xFFFF.
  - 0x0007 ÷ 0xFFFE (7/−2) → quotient 0xFFFD, remainder 0x0001.
  - Unsigned 0x8000 ÷ 0xFFFF → quotient 0, remainder 0x8000.
- Divide-by-zero: 0x1234 ÷ 0 → quotient 0xFFFF, remainder 0x1234, dbz=1, out_valid after 1 cycle. A divisor of 0 with signed_op=1 gives the same result.
- Overflow: signed 0x8000 ÷ 0xFFFF → quotient 0x8000, remainder 0, ovf=1, 1-cycle latency. The same operands unsigned → quotient 0, remainder 0x8000, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Outputs stay constant, in_ready=0, and a pulsed in_valid is ignored. Raising out_ready completes the transfer, and in_ready=1 on the next cycle.
- Reset mid-WAIT: assert rst_n=0 one cycle after accept. All outputs are 0 and in_ready=1 immediately. After release, a new request 9 ÷ 3 → quotient 3, remainder 0.
